// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Counters are 2-bit saturating values; bit [1] is the taken prediction.
package riscv_bp_pkg;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t BP_SNT = 2'b00;
    localparam bp_cnt_t BP_WNT = 2'b01;
    localparam bp_cnt_t BP_WT  = 2'b10;
    localparam bp_cnt_t BP_ST  = 2'b11;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    function automatic bp_cnt_t bp_sat_inc(input bp_cnt_t cnt);
        return (cnt == BP_ST) ? BP_ST : bp_cnt_t'(cnt + 2'd1);
    endfunction

    function automatic bp_cnt_t bp_sat_dec(input bp_cnt_t cnt);
        return (cnt == BP_SNT) ? BP_SNT : bp_cnt_t'(cnt - 2'd1);
    endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// Simple dual-port table: one synchronous read port with enable, one write port.
// A same-cycle write to the address being read is forwarded to the read data.
module riscv_bp_ram #(
    parameter int unsigned ABITS = 12,
    parameter int unsigned DBITS = 2
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] rdata_o,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] wdata_i
);

    localparam int unsigned DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [DBITS-1:0] rdata_q;

    // Storage has no reset; the owner initialises it explicitly.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_bp_gshare.sv
// Gshare predictor: PHT of 2-bit counters indexed by {GHR, PC bits}, cleared by a
// post-reset sweep, read one cycle ahead of pre-decode and updated by the branch unit.
module riscv_bp_gshare
    import riscv_bp_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned HAS_RVC        = 0,
    parameter int unsigned BP_GLOBAL_BITS = 2,
    parameter int unsigned BP_LOCAL_BITS  = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      id_stall_i,
    input  logic [XLEN-1:0]           if_nxt_pc_i,
    output logic [1:0]                bp_bp_predict_o,
    output logic [BP_GLOBAL_BITS-1:0] bp_history_o,
    output logic                      bp_init_busy_o,
    input  logic                      bu_bp_update_i,
    input  logic [XLEN-1:0]           bu_bp_pc_i,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
    input  logic [1:0]                bu_bp_predict_i,
    input  logic                      bu_bp_btaken_i
);

    localparam int unsigned LSB   = (HAS_RVC != 0) ? 1 : 2;
    localparam int unsigned GB    = BP_GLOBAL_BITS;
    localparam int unsigned ABITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;

    bp_state_t          state_q, state_d;
    logic [ABITS-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [GB-1:0]      ghr_q, ghr_d;
    logic [GB-1:0]      hist_q;
    logic               busy_q;

    logic [ABITS-1:0]   rd_idx_c;
    logic [ABITS-1:0]   wr_idx_c;
    logic               rd_en_c;
    logic               ram_we_c;
    logic [ABITS-1:0]   ram_waddr_c;
    bp_cnt_t            ram_wdata_c;
    bp_cnt_t            ram_rdata;
    logic               unused_pc_bits;

    assign rd_idx_c = {ghr_q, if_nxt_pc_i[LSB +: BP_LOCAL_BITS]};
    assign wr_idx_c = {bu_bp_history_i, bu_bp_pc_i[LSB +: BP_LOCAL_BITS]};
    // Keep reading during the sweep so the first RUN output is never stale.
    assign rd_en_c  = !id_stall_i || busy_q;

    assign unused_pc_bits = ^{if_nxt_pc_i, bu_bp_pc_i};

    // Next-state, sweep counter, GHR and PHT write-port mux.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        ghr_d       = ghr_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = wr_idx_c;
        ram_wdata_c = bu_bp_btaken_i ? bp_sat_inc(bu_bp_predict_i)
                                     : bp_sat_dec(bu_bp_predict_i);
        unique case (state_q)
            BP_INIT: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = sweep_cnt_q;
                ram_wdata_c = BP_WNT;
                sweep_cnt_d = sweep_cnt_q + ABITS'(1);
                if (&sweep_cnt_q) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                ram_we_c = bu_bp_update_i;
                if (bu_bp_update_i) begin
                    ghr_d = GB'({ghr_q, bu_bp_btaken_i});
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= BP_INIT;
            sweep_cnt_q <= '0;
            ghr_q       <= '0;
            hist_q      <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            ghr_q       <= ghr_d;
            busy_q      <= (state_d == BP_INIT);
            if (rd_en_c) begin
                hist_q <= ghr_q;
            end
        end
    end

    riscv_bp_ram #(
        .ABITS (ABITS),
        .DBITS (2)
    ) u_pht (
        .clk_i   (clk_i),
        .re_i    (rd_en_c),
        .raddr_i (rd_idx_c),
        .rdata_o (ram_rdata),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c)
    );

    assign bp_bp_predict_o = busy_q ? BP_WNT : ram_rdata;
    assign bp_history_o    = hist_q;
    assign bp_init_busy_o  = busy_q;

endmodule

// File: tb/tb_riscv_bp_gshare.sv
// Self-checking bench for riscv_bp_gshare (GLOBAL=2, LOCAL=4, 64 entries, no RVC).
module tb_riscv_bp_gshare;

    localparam int unsigned XLEN = 32;
    localparam int unsigned GB   = 2;
    localparam int unsigned LB   = 4;

    logic            clk;
    logic            rst_ni;
    logic            id_stall_i;
    logic [XLEN-1:0] if_nxt_pc_i;
    logic [1:0]      bp_bp_predict_o;
    logic [GB-1:0]   bp_history_o;
    logic            bp_init_busy_o;
    logic            bu_bp_update_i;
    logic [XLEN-1:0] bu_bp_pc_i;
    logic [GB-1:0]   bu_bp_history_i;
    logic [1:0]      bu_bp_predict_i;
    logic            bu_bp_btaken_i;

    riscv_bp_gshare #(
        .XLEN           (XLEN),
        .HAS_RVC        (0),
        .BP_GLOBAL_BITS (GB),
        .BP_LOCAL_BITS  (LB)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .id_stall_i      (id_stall_i),
        .if_nxt_pc_i     (if_nxt_pc_i),
        .bp_bp_predict_o (bp_bp_predict_o),
        .bp_history_o    (bp_history_o),
        .bp_init_busy_o  (bp_init_busy_o),
        .bu_bp_update_i  (bu_bp_update_i),
        .bu_bp_pc_i      (bu_bp_pc_i),
        .bu_bp_history_i (bu_bp_history_i),
        .bu_bp_predict_i (bu_bp_predict_i),
        .bu_bp_btaken_i  (bu_bp_btaken_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        stall;
        logic        upd;
        logic [31:0] upc;
        logic [1:0]  uhist;
        logic [1:0]  upred;
        logic        taken;
    } stim_t;

    typedef struct packed {
        logic [1:0] pred;
        logic [1:0] hist;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] pht_m [64];
    logic [1:0] ghr_m;
    logic [1:0] exp_pred_m;
    logic [1:0] exp_hist_m;
    exp_t       sb_q [$];

    function automatic logic [1:0] m_next(input logic [1:0] c, input logic t);
        case ({c, t})
            3'b000:  return 2'b00;
            3'b001:  return 2'b01;
            3'b010:  return 2'b00;
            3'b011:  return 2'b10;
            3'b100:  return 2'b01;
            3'b101:  return 2'b11;
            3'b110:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) pht_m[i] = 2'b01;
        ghr_m      = 2'b00;
        exp_pred_m = 2'b01;
        exp_hist_m = 2'b00;
        sb_q.delete();
    endtask

    // Drive one RUN cycle and push the outputs expected after its edge.
    task automatic drive_cycle(input stim_t s);
        logic [5:0] ridx;
        logic [5:0] widx;
        if_nxt_pc_i     = s.pc;
        id_stall_i      = s.stall;
        bu_bp_update_i  = s.upd;
        bu_bp_pc_i      = s.upc;
        bu_bp_history_i = s.uhist;
        bu_bp_predict_i = s.upred;
        bu_bp_btaken_i  = s.taken;
        ridx = {ghr_m, s.pc[5:2]};
        if (s.upd) begin
            widx = {s.uhist, s.upc[5:2]};
            pht_m[widx] = m_next(s.upred, s.taken);
        end
        if (!s.stall) begin
            exp_pred_m = pht_m[ridx];
            exp_hist_m = ghr_m;
        end
        if (s.upd) ghr_m = {ghr_m[0], s.taken};
        sb_q.push_back('{pred: exp_pred_m, hist: exp_hist_m});
        @(posedge clk);
        #1;
        bu_bp_update_i = 1'b0;
        id_stall_i     = 1'b0;
    endtask

    task automatic test_reset();
        int   cnt;
        int   bad;
        exp_t e;
        stim_t s;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bp_bp_predict_o !== 2'b01 || bp_history_o !== 2'b00 || bp_init_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: predict=%b history=%b busy=%b, required 01/00/1",
                     bp_bp_predict_o, bp_history_o, bp_init_busy_o);
        end
        rst_ni = 1'b1;
        model_reset();
        cnt = 0;
        bad = 0;
        while (bp_init_busy_o === 1'b1 && cnt < 200) begin
            if (bp_bp_predict_o !== 2'b01) bad++;
            cnt++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (cnt != 64) begin
            n_fail++;
            $display("FAIL init_length: busy cycles=%0d, required 64", cnt);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL init_predict: %0d busy cycles with predict!=01, required 0", bad);
        end
        for (int i = 0; i < 16; i++) begin
            s = '{pc: 32'(i * 4), stall: 1'b0, upd: 1'b0, upc: 32'h0, uhist: 2'b00, upred: 2'b00, taken: 1'b0};
            drive_cycle(s);
            e = sb_q.pop_front();
            n_tests++;
            if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_init_read[%0d]: predict=%b history=%b busy=%b, required %b/%b/0",
                         i, bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
            end
        end
    endtask

    task automatic test_init_update();
        int    cnt;
        exp_t  e;
        stim_t s;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            bu_bp_update_i  = 1'b1;
            bu_bp_pc_i      = 32'h40;
            bu_bp_history_i = 2'b00;
            bu_bp_predict_i = 2'b01;
            bu_bp_btaken_i  = 1'b1;
            @(posedge clk);
            #1;
        end
        bu_bp_update_i = 1'b0;
        cnt = 5;
        while (bp_init_busy_o === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (cnt != 64) begin
            n_fail++;
            $display("FAIL init_update_length: busy cycles=%0d, required 64", cnt);
        end
        s = '{pc: 32'h40, stall: 1'b0, upd: 1'b0, upc: 32'h0, uhist: 2'b00, upred: 2'b00, taken: 1'b0};
        drive_cycle(s);
        e = sb_q.pop_front();
        n_tests++;
        if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL init_update_ignored: predict=%b history=%b busy=%b, required %b/%b/0",
                     bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
        end
    endtask

    task automatic test_update();
        stim_t tbl [8];
        exp_t  e;
        tbl[0] = '{32'h40, 1'b0, 1'b1, 32'h40, 2'b00, 2'b01, 1'b1};
        tbl[1] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[2] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[3] = '{32'h40, 1'b0, 1'b1, 32'h40, 2'b00, 2'b11, 1'b1};
        tbl[4] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[5] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[6] = '{32'h40, 1'b0, 1'b1, 32'h40, 2'b00, 2'b00, 1'b0};
        tbl[7] = '{32'h40, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(tbl[i]);
            e = sb_q.pop_front();
            n_tests++;
            if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL update[%0d]: predict=%b history=%b busy=%b, required %b/%b/0",
                         i, bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
            end
        end
    endtask

    task automatic test_ghr();
        stim_t tbl [7];
        exp_t  e;
        tbl[0] = '{32'h00, 1'b0, 1'b1, 32'h00, 2'b01, 2'b10, 1'b1};
        tbl[1] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[2] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[3] = '{32'h00, 1'b0, 1'b1, 32'h0C, 2'b00, 2'b01, 1'b1};
        tbl[4] = '{32'h00, 1'b0, 1'b1, 32'h0C, 2'b01, 2'b01, 1'b0};
        tbl[5] = '{32'h00, 1'b0, 1'b1, 32'h0C, 2'b10, 2'b01, 1'b1};
        tbl[6] = '{32'h00, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_cycle(tbl[i]);
            e = sb_q.pop_front();
            n_tests++;
            if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ghr[%0d]: predict=%b history=%b busy=%b, required %b/%b/0",
                         i, bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
            end
        end
        // Read of PC 0 after 1,0,1 must use index {01,0000}, preloaded to 11.
        n_tests++;
        if (bp_bp_predict_o !== 2'b11 || bp_history_o !== 2'b01) begin
            n_fail++;
            $display("FAIL ghr_index: predict=%b history=%b, required 11/01",
                     bp_bp_predict_o, bp_history_o);
        end
    endtask

    task automatic test_back_to_back_bypass();
        stim_t tbl [4];
        exp_t  e;
        tbl[0] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[1] = '{32'h00, 1'b0, 1'b1, 32'h08, 2'b00, 2'b00, 1'b0};
        tbl[2] = '{32'h04, 1'b0, 1'b1, 32'h04, 2'b00, 2'b10, 1'b1};
        tbl[3] = '{32'h04, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(tbl[i]);
            e = sb_q.pop_front();
            n_tests++;
            if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass[%0d]: predict=%b history=%b busy=%b, required %b/%b/0",
                         i, bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
            end
            if (i == 2) begin
                n_tests++;
                if (bp_bp_predict_o !== 2'b11 || bp_history_o !== 2'b00) begin
                    n_fail++;
                    $display("FAIL bypass_same_cycle: predict=%b history=%b, required 11/00",
                             bp_bp_predict_o, bp_history_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        stim_t tbl [4];
        exp_t  e;
        tbl[0] = '{32'h00, 1'b1, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        tbl[1] = '{32'h08, 1'b1, 1'b1, 32'h20, 2'b00, 2'b01, 1'b1};
        tbl[2] = '{32'h40, 1'b1, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        tbl[3] = '{32'h20, 1'b0, 1'b0, 32'h00, 2'b00, 2'b00, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(tbl[i]);
            e = sb_q.pop_front();
            n_tests++;
            if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d]: predict=%b history=%b busy=%b, required %b/%b/0",
                         i, bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
            end
        end
    endtask

    task automatic test_reset_mid();
        int    cnt;
        exp_t  e;
        stim_t s;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bp_bp_predict_o !== 2'b01 || bp_history_o !== 2'b00 || bp_init_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_run: predict=%b history=%b busy=%b, required 01/00/1",
                     bp_bp_predict_o, bp_history_o, bp_init_busy_o);
        end
        rst_ni = 1'b1;
        model_reset();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cnt = 0;
        while (bp_init_busy_o === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (cnt != 64) begin
            n_fail++;
            $display("FAIL reset_mid_sweep_length: busy cycles=%0d, required 64", cnt);
        end
        s = '{pc: 32'h04, stall: 1'b0, upd: 1'b0, upc: 32'h0, uhist: 2'b00, upred: 2'b00, taken: 1'b0};
        drive_cycle(s);
        e = sb_q.pop_front();
        n_tests++;
        if (bp_bp_predict_o !== e.pred || bp_history_o !== e.hist || bp_init_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resweep: predict=%b history=%b busy=%b, required %b/%b/0",
                     bp_bp_predict_o, bp_history_o, bp_init_busy_o, e.pred, e.hist);
        end
    endtask

    initial begin
        rst_ni          = 1'b0;
        id_stall_i      = 1'b0;
        if_nxt_pc_i     = '0;
        bu_bp_update_i  = 1'b0;
        bu_bp_pc_i      = '0;
        bu_bp_history_i = '0;
        bu_bp_predict_i = '0;
        bu_bp_btaken_i  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_init_update();
        test_update();
        test_ghr();
        test_back_to_back_bypass();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
